mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared-memory controller for the cached pipeline. It arbitrates between instruction-cache miss fills and data-cache fills and write-through stores, and sequences each granted transaction onto the single pipelined main-memory port. Block fills are issued as back-to-back word reads, and the returned words are steered to the owning cache. The block sits between the two cache controllers and the multi-cycle main memory.

## Interface
- ADDR_WIDTH, 16, byte address width
- BLOCK_WORDS, 8, 16-bit words per cache block (power of 2, ≥2)
- MEM_LATENCY, 4, cycles from a read issue (mem_enable=1, mem_wr=0) to mem_data_valid for that word; memory accepts one request per cycle

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  I-cache fill request, level, held until i_done
- i_addr  in  ADDR_WIDTH  I-cache miss address (any byte in block)
- i_data  out  16  fill word
- i_valid  out  1  i_data valid this cycle
- i_widx  out  $clog2(BLOCK_WORDS)  word index of i_data within block
- i_done  out  1  one-cycle pulse, fill complete
- d_req  in  1  D-cache request, level, held until d_done
- d_wr  in  1  1 = single-word write, 0 = block fill; sampled at grant
- d_addr  in  ADDR_WIDTH  D-cache address
- d_wdata  in  16  write data; sampled at grant
- d_data, d_valid, d_widx, d_done  out  as I-side equivalents
- mem_enable  out  1  memory request
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_WIDTH  word-aligned memory address (bit 0 always 0)
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_data_valid  in  1  mem_rdata valid

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE.
- IDLE: if d_req, go to D_WRITE (d_wr=1) or D_FILL (d_wr=0). Otherwise, if i_req, go to I_FILL. The D side has fixed priority.
- At grant, latch the base address. For fills, this is the request address with the low log2(BLOCK_WORDS)+1 bits cleared. For writes, it is the address with bit 0 cleared. Also latch d_wdata.
- Fill: the issue counter runs 0..BLOCK_WORDS-1. Each cycle assert mem_enable=1, mem_wr=0, mem_addr=base+2*count. The receive counter increments on each mem_data_valid.
- Return routing: x_data=mem_rdata, x_valid=mem_data_valid, x_widx=receive count, for the owner x only. The other side's outputs stay 0.
- x_done pulses in the same cycle as the last valid word (receive count BLOCK_WORDS-1). The next state is IDLE.
- D_WRITE: one cycle with mem_enable=1, mem_wr=1, mem_addr=base, mem_wdata=latched data; d_done=1 in that cycle. The next state is IDLE.
- Outside issue cycles: mem_enable=0, mem_wr=0.
- mem_data_valid in IDLE, in D_WRITE, or beyond BLOCK_WORDS returns is ignored.
- Request deassertion mid-transaction is ignored; the transaction completes and done still pulses.
- Requests arriving while busy wait; arbitration happens only in IDLE.
- Reset (any state, including mid-fill): state IDLE, counters 0, all outputs 0. In-flight memory data after reset is ignored.

## Timing
- Cycle 0 is the IDLE cycle in which the request is seen. The grant is registered at the end of cycle 0.
- Fill: issues in cycles 1..BLOCK_WORDS. Data returns in cycles 1+MEM_LATENCY..BLOCK_WORDS+MEM_LATENCY. done is asserted in cycle BLOCK_WORDS+MEM_LATENCY. The next arbitration happens in the following cycle, so occupancy is BLOCK_WORDS+MEM_LATENCY+1 cycles.
- Write: issue and d_done both in cycle 1; IDLE in cycle 2. Occupancy is 2 cycles.
- Exactly one IDLE cycle separates consecutive transactions.
- All outputs are combinational from registered state and counters, except x_data/x_valid, which also pass mem_rdata/mem_data_valid through combinationally.

## Test plan
- **I-fill alone** (MEM_LATENCY=4, BLOCK_WORDS=8): i_req with i_addr=0x1236 -> mem_addr 0x1230,0x1232,…,0x123E in cycles 1–8. i_valid with i_widx 0..7 in cycles 5–12. i_done in cycle 12; no d_* activity.
- **Simultaneous requests**: i_req and d_req (d_wr=0, d_addr=0x0040) in the same cycle -> D_FILL of 0x0040–0x004E first, d_done in cycle 12. I_FILL is granted in cycle 13, with its first issue in cycle 14.
- **Write-through**: d_req, d_wr=1, d_addr=0x0103, d_wdata=0xBEEF -> cycle 1: mem_enable=1, mem_wr=1, mem_addr=0x0102, mem_wdata=0xBEEF, d_done=1. IDLE in cycle 2.
- **Request while busy**: d_req write raised in cycle 3 of an I-fill -> no issue until the I-fill completes. The write issues 2 cycles after i_done.
- **Reset mid-fill**: rst in cycle 6 of an I-fill -> the next cycle shows all outputs 0. A late mem_data_valid produces no i_valid. A new i_req is granted from IDLE.
- **Dropped request**: i_req deasserted in cycle 2 of a fill -> all 8 issues still occur and i_done still pulses in cycle 12.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one pipelined main-memory port between the I-cache (block fills)
// and the D-cache (block fills and single-word write-through stores).
// The D side has fixed priority. Arbitration happens only in IDLE, and each
// granted transaction runs to completion before the next grant.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   i_req, i_addr        I-cache fill request (level) and miss address
//   i_data, i_valid,     returned fill word, its strobe, and its word index
//   i_widx, i_done       within the block; one-cycle completion pulse
//   d_req, d_wr,         D-cache request (level), write/fill select, address,
//   d_addr, d_wdata      and write data (d_wr/d_wdata sampled at grant)
//   d_data, d_valid,     D-side equivalents of the I-side return signals
//   d_widx, d_done
//   mem_enable, mem_wr,  memory request, write select, word-aligned address
//   mem_addr, mem_wdata  and write data
//   mem_rdata,           memory read data and its strobe (MEM_LATENCY
//   mem_data_valid       cycles after the read issue)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_req,
    input  logic [ADDR_WIDTH-1:0]          i_addr,
    output logic [15:0]                    i_data,
    output logic                           i_valid,
    output logic [$clog2(BLOCK_WORDS)-1:0] i_widx,
    output logic                           i_done,
    input  logic                           d_req,
    input  logic                           d_wr,
    input  logic [ADDR_WIDTH-1:0]          d_addr,
    input  logic [15:0]                    d_wdata,
    output logic [15:0]                    d_data,
    output logic                           d_valid,
    output logic [$clog2(BLOCK_WORDS)-1:0] d_widx,
    output logic                           d_done,
    output logic                           mem_enable,
    output logic                           mem_wr,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata,
    input  logic                           mem_data_valid
);

    localparam int WIDX_W = $clog2(BLOCK_WORDS);
    // The issue counter needs one extra bit so it can hold BLOCK_WORDS,
    // which marks "all reads issued, only waiting for returns".
    localparam int ICNT_W = WIDX_W + 1;

    localparam logic [WIDX_W-1:0]     LAST_WORD = WIDX_W'(BLOCK_WORDS - 1);
    localparam logic [ICNT_W-1:0]     ISSUE_END = ICNT_W'(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] FILL_MASK = ~(ADDR_WIDTH'(2 * BLOCK_WORDS - 1));
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(1));

    if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 || MEM_LATENCY < 1) begin : g_bad_param
        $error("mem_arbiter: BLOCK_WORDS must be a power of 2 >= 2 and MEM_LATENCY >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ICNT_W-1:0]       iss_cnt_q;
    logic [WIDX_W-1:0]       rcv_cnt_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   base_d;
    logic [15:0]             wdata_q;

    logic in_fill;
    logic issuing;
    logic rx;
    logic last_rx;
    logic i_own;
    logic d_own;

    assign in_fill = (state_q == I_FILL) || (state_q == D_FILL);
    assign issuing = in_fill && (iss_cnt_q != ISSUE_END);
    // Returns outside a fill (IDLE, D_WRITE, or stale data after reset while
    // idle) never reach either cache.
    assign rx      = in_fill && mem_data_valid;
    assign last_rx = rx && (rcv_cnt_q == LAST_WORD);
    assign i_own   = (state_q == I_FILL);
    assign d_own   = (state_q == D_FILL);

    // Base address chosen by the same priority as the grant itself.
    always_comb begin
        base_d = i_addr & FILL_MASK;
        if (d_req) begin
            base_d = d_wr ? (d_addr & WORD_MASK) : (d_addr & FILL_MASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            iss_cnt_q <= '0;
            rcv_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    iss_cnt_q <= '0;
                    rcv_cnt_q <= '0;
                    if (d_req) begin
                        state_q <= d_wr ? D_WRITE : D_FILL;
                    end else if (i_req) begin
                        state_q <= I_FILL;
                    end
                end
                I_FILL, D_FILL: begin
                    // Request level is not consulted here: a dropped request
                    // still runs the fill to completion.
                    if (issuing) begin
                        iss_cnt_q <= iss_cnt_q + ICNT_W'(1);
                    end
                    if (rx) begin
                        rcv_cnt_q <= rcv_cnt_q + WIDX_W'(1);
                    end
                    if (last_rx) begin
                        state_q <= IDLE;
                    end
                end
                D_WRITE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Address/data latches need no reset: every output they feed is gated
    // by the state, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && (d_req || i_req)) begin
            base_q  <= base_d;
            wdata_q <= d_wdata;
        end
    end

    assign mem_enable = issuing || (state_q == D_WRITE);
    assign mem_wr     = (state_q == D_WRITE);
    // In D_WRITE the issue counter is still 0, so this is just the base.
    assign mem_addr   = mem_enable ? (base_q + (ADDR_WIDTH'(iss_cnt_q) << 1)) : '0;
    assign mem_wdata  = mem_wr ? wdata_q : '0;

    assign i_valid = i_own && mem_data_valid;
    assign i_data  = i_own ? mem_rdata : '0;
    assign i_widx  = i_own ? rcv_cnt_q : '0;
    assign i_done  = i_own && last_rx;

    assign d_valid = d_own && mem_data_valid;
    assign d_data  = d_own ? mem_rdata : '0;
    assign d_widx  = d_own ? rcv_cnt_q : '0;
    assign d_done  = (d_own && last_rx) || (state_q == D_WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives directed scenarios followed by randomized request traffic into
// mem_arbiter. A word-addressed memory with fixed read latency answers the
// DUT's bus. A transaction-level model predicts every output on every cycle
// from the grant cycle and the documented fill/write timeline.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int BW = 8;
    localparam int L  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic        i_valid;
    logic [2:0]  i_widx;
    logic        i_done;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_data;
    logic        d_valid;
    logic [2:0]  d_widx;
    logic        d_done;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .BLOCK_WORDS(BW),
        .MEM_LATENCY(L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_widx        (i_widx),
        .i_done        (i_done),
        .d_req         (d_req),
        .d_wr          (d_wr),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_data        (d_data),
        .d_valid       (d_valid),
        .d_widx        (d_widx),
        .d_done        (d_done),
        .mem_enable    (mem_enable),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_data_valid(mem_data_valid)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Memory: word array plus pending read returns.
    logic [15:0] mem_arr [0:32767];
    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;
    rsp_t pend[$];

    // Transaction-level model: kind 0 = I fill, 1 = D fill, 2 = D write.
    bit          m_busy = 1'b0;
    int          m_kind = 0;
    int          m_g    = 0;
    logic [15:0] m_base = '0;
    logic [15:0] m_wd   = '0;

    // Requester bookkeeping.
    bit i_active = 0, d_active = 0;
    bit i_granted = 0, d_granted = 0;
    bit i_done_evt = 0, d_done_evt = 0;
    bit rnd_mode = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        logic        e_en, e_wr;
        logic [15:0] e_addr, e_wd;
        logic        e_iv, e_idn, e_dv, e_ddn;
        logic [2:0]  e_iw, e_dw;
        logic [15:0] e_id, e_dd;
        int          k;
        int          rc;
        bit          v;
        bit          fin;
        e_en = 0; e_wr = 0; e_addr = '0; e_wd = '0;
        e_iv = 0; e_idn = 0; e_iw = '0; e_id = '0;
        e_dv = 0; e_ddn = 0; e_dw = '0; e_dd = '0;
        fin = 0;
        k = cyc - m_g;
        if (m_busy) begin
            if (m_kind == 2) begin
                if (k == 1) begin
                    e_en = 1; e_wr = 1; e_addr = m_base; e_wd = m_wd; e_ddn = 1;
                end
                fin = (k >= 1);
            end else begin
                if (k >= 1 && k <= BW) begin
                    e_en   = 1;
                    e_addr = m_base + 16'(2 * (k - 1));
                end
                v   = (k >= 1 + L);
                rc  = v ? (k - 1 - L) : 0;
                fin = v && (rc == BW - 1);
                if (m_kind == 0) begin
                    e_iv = v; e_iw = 3'(rc); e_id = mem_rdata; e_idn = fin;
                end else begin
                    e_dv = v; e_dw = 3'(rc); e_dd = mem_rdata; e_ddn = fin;
                end
            end
        end
        chk("mem_bus", 64'({mem_enable, mem_wr, mem_addr, mem_wdata}),
                       64'({e_en, e_wr, e_addr, e_wd}));
        chk("i_side",  64'({i_valid, i_widx, i_data, i_done}),
                       64'({e_iv, e_iw, e_id, e_idn}));
        chk("d_side",  64'({d_valid, d_widx, d_data, d_done}),
                       64'({e_dv, e_dw, e_dd, e_ddn}));

        // Memory answers whatever appears on the bus.
        if (mem_enable === 1'b1 && mem_wr === 1'b0)
            pend.push_back('{due: cyc + L, data: mem_arr[mem_addr[15:1]]});
        if (mem_enable === 1'b1 && mem_wr === 1'b1)
            mem_arr[mem_addr[15:1]] = mem_wdata;

        if (m_busy && fin) begin
            if (m_kind == 0) i_done_evt = 1;
            else             d_done_evt = 1;
        end
        if (rst) begin
            m_busy = 0;
        end else if (m_busy) begin
            if (fin) m_busy = 0;
        end else if (d_req) begin
            m_busy = 1; m_g = cyc; m_kind = d_wr ? 2 : 1;
            m_base = d_wr ? (d_addr & 16'hFFFE) : (d_addr & ~16'(2 * BW - 1));
            m_wd   = d_wdata;
            d_granted = 1;
        end else if (i_req) begin
            m_busy = 1; m_g = cyc; m_kind = 0;
            m_base = i_addr & ~16'(2 * BW - 1);
            i_granted = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            mem_data_valid = 1'b1;
            mem_rdata      = pend[0].data;
            pend.delete(0);
        end else begin
            mem_data_valid = 1'b0;
            mem_rdata      = 16'($urandom);
        end
        if (i_done_evt) begin
            i_req = 0; i_active = 0; i_granted = 0; i_done_evt = 0;
        end
        if (d_done_evt) begin
            d_req = 0; d_active = 0; d_granted = 0; d_done_evt = 0;
        end
        if (rnd_mode) begin
            // After grant, the held address/data must no longer matter.
            if (i_granted) begin
                i_addr = 16'($urandom);
                if ($urandom_range(0, 7) == 0) i_req = 0;
            end
            if (d_granted) begin
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
                d_wr    = 1'($urandom);
                if ($urandom_range(0, 7) == 0) d_req = 0;
            end
            if (!i_active && $urandom_range(0, 3) == 0) begin
                i_req = 1; i_active = 1; i_addr = 16'($urandom);
            end
            if (!d_active && $urandom_range(0, 4) == 0) begin
                d_req = 1; d_active = 1; d_addr = 16'($urandom);
                d_wr = 1'($urandom); d_wdata = 16'($urandom);
            end
        end
    endtask

    task automatic req_i(input logic [15:0] a);
        i_req = 1; i_addr = a; i_active = 1;
    endtask

    task automatic req_d(input logic wr, input logic [15:0] a, input logic [15:0] wd);
        d_req = 1; d_wr = wr; d_addr = a; d_wdata = wd; d_active = 1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_busy || i_active || d_active) && n < budget) begin
            tick();
            n++;
        end
        if (m_busy || i_active || d_active) chk("drain_timeout", 64'(n), 64'(budget + 1));
        tick();
    endtask

    initial begin
        rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_data_valid = 0;
        for (int a = 0; a < 32768; a++) mem_arr[a] = 16'($urandom);
        @(posedge clk);
        #1;
        repeat (3) tick();
        rst = 0;
        tick();

        // I-fill alone.
        req_i(16'h1236);
        drain(40);

        // Simultaneous requests: D fill wins, I fill follows.
        req_i(16'h2222);
        req_d(1'b0, 16'h0040, 16'h0000);
        drain(60);

        // Write-through.
        req_d(1'b1, 16'h0103, 16'hBEEF);
        drain(10);

        // Write request arriving during an I fill.
        req_i(16'h3000);
        repeat (3) tick();
        req_d(1'b1, 16'h3011, 16'h1234);
        drain(60);

        // Reset in cycle 6 of a fill, stale returns afterwards, then a new fill.
        req_i(16'h4444);
        repeat (6) tick();
        rst = 1; i_req = 0; i_active = 0; i_granted = 0;
        tick();
        rst = 0;
        repeat (L + 3) tick();
        req_i(16'h4450);
        drain(40);

        // Request dropped in cycle 2 of a fill.
        req_i(16'h2008);
        repeat (2) tick();
        i_req = 0;
        drain(40);

        // Randomized traffic.
        rnd_mode = 1;
        repeat (3000) tick();
        rnd_mode = 0;
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
